// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, address type and write-port priority helper for regfile_mp
package regfile_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int MAX_WR       = 16;

    typedef logic [$clog2(DEF_NUM_REGS)-1:0] addr_t;

    // One-hot of the highest-index set bit: the winning write port among the matches.
    function automatic logic [MAX_WR-1:0] pick_wr(input logic [MAX_WR-1:0] match);
        pick_wr = '0;
        for (int k = 0; k < MAX_WR; k++) if (match[k]) pick_wr = MAX_WR'(1) << k;
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and reserve bus of the multi-port register file
//   rd_addr/rd_data/rd_busy : NUM_RD read ports (data and scoreboard flag)
//   wr_en/wr_addr/wr_data   : NUM_WR write ports
//   rsv_en/rsv_addr         : reserve request that marks a pending write
interface regfile_mp_if #(
    parameter int DATA_W = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W = $clog2(regfile_pkg::DEF_NUM_REGS),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic                          rsv_en;
    logic [ADDR_W-1:0]             rsv_addr;

    modport master (output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, input rd_data, rd_busy);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, output rd_data, rd_busy);
endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port's same-cycle write bypass mux and busy mask
//   rd_addr, st_data, st_busy   : address and the stored value/busy already fetched for it
//   wr_*, rsv_*                 : this cycle's (reset-gated) writes and reservation
//   rd_data, rd_busy            : port outputs
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter bit R0_ZERO  = 1'b0
) (
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [DATA_W-1:0]             st_data,
    input  logic                          st_busy,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
    input  logic                          rsv_en,
    input  logic [ADDR_W-1:0]             rsv_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_busy
);
    logic [MAX_WR-1:0] match, sel;
    logic [DATA_W-1:0] byp_data;
    logic ok, hit;

    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_WR; k++) match[k] = wr_en[k] && wr_addr[k] == rd_addr;
        sel = pick_wr(match);
        byp_data = '0;
        for (int k = 0; k < NUM_WR; k++) byp_data |= sel[k] ? wr_data[k] : '0;
    end

    // Only real, writable registers can be bypassed.
    assign ok      = int'(rd_addr) < NUM_REGS && !(R0_ZERO && rd_addr == '0);
    assign hit     = BYPASS != 0 && ok && |sel;
    assign rd_data = hit ? byp_data : st_data;
    // A bypassed write releases the register unless a new reservation lands on it at the same edge.
    assign rd_busy = st_busy && !(hit && !(rsv_en && rsv_addr == rd_addr));
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write priority, optional bypass and busy scoreboard
//   clk, rst_n : clock and asynchronous active-low reset (clears data and busy)
//   bus        : regfile_mp_if slave (NUM_RD read ports, NUM_WR write ports, reserve)
//   REGFILE_R0_ZERO_EN : when defined, register 0 is hardwired to zero and never busy
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0]             busy_q;
    logic [NUM_WR-1:0]               wr_ok;
    logic                            rsv_ok;

    // Gating with reset keeps writes presented during reset from reaching the bypass path.
    assign wr_ok  = bus.wr_en & {NUM_WR{rst_n}};
    assign rsv_ok = bus.rsv_en && rst_n;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (R0_ZERO && r == 0) begin : g_zero
            assign regs_q[r] = '0;
            assign busy_q[r] = 1'b0;
        end else begin : g_store
            logic [MAX_WR-1:0] match, sel;
            logic [DATA_W-1:0] d, q;
            logic              b;
            always_comb begin
                match = '0;
                for (int k = 0; k < NUM_WR; k++) match[k] = wr_ok[k] && bus.wr_addr[k] == ADDR_W'(r);
                sel = pick_wr(match);
                d = '0;
                for (int k = 0; k < NUM_WR; k++) d |= sel[k] ? bus.wr_data[k] : '0;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                    b <= 1'b0;
                end else begin
                    if (|sel) q <= d;
                    // Reserve beats release: the new reservation supersedes the completing write.
                    b <= (rsv_ok && bus.rsv_addr == ADDR_W'(r)) || (b && !(|sel));
                end
            end
            assign regs_q[r] = q;
            assign busy_q[r] = b;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [DATA_W-1:0] st;
        logic              sb;
        // Addresses beyond NUM_REGS match no register and therefore read 0, not busy.
        always_comb begin
            st = '0;
            sb = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (bus.rd_addr[i] == ADDR_W'(r)) begin
                    st = regs_q[r];
                    sb = busy_q[r];
                end
            end
        end
        regfile_rd_port #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
            .NUM_WR(NUM_WR), .BYPASS(BYPASS), .R0_ZERO(R0_ZERO)
        ) u_rd (
            .rd_addr (bus.rd_addr[i]),
            .st_data (st),
            .st_busy (sb),
            .wr_en   (wr_ok),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .rsv_en  (rsv_ok),
            .rsv_addr(bus.rsv_addr),
            .rd_data (bus.rd_data[i]),
            .rd_busy (bus.rd_busy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed check of regfile_mp (bypass and no-bypass instances) against a behavioural model
module tb_regfile_mp;
    localparam int DW = 32, NR = 24, AW = 5, NRD = 3, NWR = 2;
`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mreg [NR] = '{default: '0};
    logic          mbusy [NR] = '{default: 1'b0};

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) b0 ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) b1 ();

    assign b1.rd_addr  = b0.rd_addr;
    assign b1.wr_en    = b0.wr_en;
    assign b1.wr_addr  = b0.wr_addr;
    assign b1.wr_data  = b0.wr_data;
    assign b1.rsv_en   = b0.rsv_en;
    assign b1.rsv_addr = b0.rsv_addr;

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    always #5 clk = ~clk;

    function automatic bit ok(input int a);
        return a < NR && !(R0Z && a == 0);
    endfunction

    function automatic bit wr_hit(input int a);
        bit h = 1'b0;
        for (int k = 0; k < NWR; k++) if (b0.wr_en[k] && int'(b0.wr_addr[k]) == a) h = 1'b1;
        return h;
    endfunction

    function automatic logic [DW-1:0] exp_data(input int i, input bit byp);
        int a;
        logic [DW-1:0] v;
        a = int'(b0.rd_addr[i]);
        if (!rst_n || !ok(a)) return '0;
        v = mreg[a];
        if (byp) for (int k = 0; k < NWR; k++) if (b0.wr_en[k] && int'(b0.wr_addr[k]) == a) v = b0.wr_data[k];
        return v;
    endfunction

    function automatic logic exp_busy(input int i, input bit byp);
        int a;
        a = int'(b0.rd_addr[i]);
        if (!rst_n || !ok(a)) return 1'b0;
        if (byp && wr_hit(a) && !(b0.rsv_en && int'(b0.rsv_addr) == a)) return 1'b0;
        return mbusy[a];
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic look(input string nm, input int i, input logic [DW-1:0] d0, input logic k0,
                        input logic [DW-1:0] d1, input logic k1);
        chk({nm, "_byp_data"}, b0.rd_data[i], d0);
        chk({nm, "_byp_busy"}, DW'(b0.rd_busy[i]), DW'(k0));
        chk({nm, "_nob_data"}, b1.rd_data[i], d1);
        chk({nm, "_nob_busy"}, DW'(b1.rd_busy[i]), DW'(k1));
    endtask

    task automatic idle();
        b0.rd_addr  = '0;
        b0.wr_en    = '0;
        b0.wr_addr  = '0;
        b0.wr_data  = '0;
        b0.rsv_en   = 1'b0;
        b0.rsv_addr = '0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 9));
    endfunction

    // Architectural model: writes in port order (last wins), then the reservation (set wins).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) begin
                mreg[r]  = '0;
                mbusy[r] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (b0.wr_en[k] && ok(int'(b0.wr_addr[k]))) begin
                    mreg[int'(b0.wr_addr[k])]  = b0.wr_data[k];
                    mbusy[int'(b0.wr_addr[k])] = 1'b0;
                end
            end
            if (b0.rsv_en && ok(int'(b0.rsv_addr))) mbusy[int'(b0.rsv_addr)] = 1'b1;
        end
    end

    always @(negedge clk) begin
        #2;
        for (int i = 0; i < NRD; i++) begin
            chk($sformatf("model_byp_data%0d", i), b0.rd_data[i], exp_data(i, 1'b1));
            chk($sformatf("model_byp_busy%0d", i), DW'(b0.rd_busy[i]), DW'(exp_busy(i, 1'b1)));
            chk($sformatf("model_nob_data%0d", i), b1.rd_data[i], exp_data(i, 1'b0));
            chk($sformatf("model_nob_busy%0d", i), DW'(b1.rd_busy[i]), DW'(exp_busy(i, 1'b0)));
        end
    end

    initial begin
        idle();
        repeat (2) begin
            @(negedge clk);
            b0.wr_en = 2'b11;
            b0.wr_addr[0] = 5'd1;
            b0.wr_addr[1] = 5'd2;
            b0.wr_data[0] = 32'hCAFE0001;
            b0.wr_data[1] = 32'hCAFE0002;
            b0.rsv_en = 1'b1;
            b0.rsv_addr = 5'd1;
            b0.rd_addr[0] = 5'd1;
            b0.rd_addr[1] = 5'd2;
            b0.rd_addr[2] = 5'd0;
            #3;
            for (int i = 0; i < NRD; i++) look("in_reset", i, '0, 1'b0, '0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int a = 0; a < 32; a += 3) begin
            @(negedge clk);
            for (int i = 0; i < NRD; i++) b0.rd_addr[i] = AW'(a + i);
            #3;
            for (int i = 0; i < NRD; i++) look("after_reset", i, '0, 1'b0, '0, 1'b0);
        end

        @(negedge clk);
        idle();
        b0.wr_en = 2'b01;
        b0.wr_addr[0] = 5'd5;
        b0.wr_data[0] = 32'hDEADBEEF;
        b0.rd_addr[0] = 5'd5;
        #1 rst_n = 1'b0;
        #2 look("rst_midwr", 0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        b0.rd_addr[0] = 5'd5;
        #3 look("rst_midwr_after", 0, '0, 1'b0, '0, 1'b0);

        @(negedge clk);
        idle();
        b0.wr_en = 2'b01;
        b0.wr_addr[0] = 5'd5;
        b0.wr_data[0] = 32'hDEADBEEF;
        @(negedge clk);
        idle();
        b0.rd_addr[0] = 5'd5;
        #3 look("r5_written", 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
        #1 rst_n = 1'b0;
        #1 look("r5_async_clear", 0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        idle();
        b0.wr_en = 2'b01;
        b0.wr_addr[0] = 5'd3;
        b0.wr_data[0] = 32'h12345678;
        b0.rd_addr[0] = 5'd3;
        #3 look("r3_same_cycle", 0, 32'h12345678, 1'b0, '0, 1'b0);
        @(negedge clk);
        idle();
        b0.rd_addr[0] = 5'd3;
        #3 look("r3_next_cycle", 0, 32'h12345678, 1'b0, 32'h12345678, 1'b0);

        @(negedge clk);
        idle();
        b0.wr_en = 2'b11;
        b0.wr_addr[0] = 5'd7;
        b0.wr_addr[1] = 5'd7;
        b0.wr_data[0] = 32'hAAAA;
        b0.wr_data[1] = 32'hBBBB;
        b0.rd_addr[1] = 5'd7;
        #3 look("r7_collide_byp", 1, 32'hBBBB, 1'b0, '0, 1'b0);
        @(negedge clk);
        idle();
        b0.rd_addr[1] = 5'd7;
        #3 look("r7_collide", 1, 32'hBBBB, 1'b0, 32'hBBBB, 1'b0);

        @(negedge clk);
        idle();
        b0.rsv_en = 1'b1;
        b0.rsv_addr = 5'd9;
        b0.rd_addr[2] = 5'd9;
        #3 look("r9_rsv_cycle", 2, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        idle();
        b0.rd_addr[2] = 5'd9;
        #3 look("r9_busy", 2, '0, 1'b1, '0, 1'b1);
        @(negedge clk);
        idle();
        b0.wr_en = 2'b10;
        b0.wr_addr[1] = 5'd9;
        b0.wr_data[1] = 32'h55;
        b0.rd_addr[2] = 5'd9;
        #3 look("r9_wr_cycle", 2, 32'h55, 1'b0, '0, 1'b1);
        @(negedge clk);
        idle();
        b0.rd_addr[2] = 5'd9;
        #3 look("r9_released", 2, 32'h55, 1'b0, 32'h55, 1'b0);
        @(negedge clk);
        idle();
        b0.rsv_en = 1'b1;
        b0.rsv_addr = 5'd9;
        b0.rd_addr[2] = 5'd9;
        @(negedge clk);
        idle();
        b0.rsv_en = 1'b1;
        b0.rsv_addr = 5'd9;
        b0.wr_en = 2'b01;
        b0.wr_addr[0] = 5'd9;
        b0.wr_data[0] = 32'h66;
        b0.rd_addr[2] = 5'd9;
        #3 look("r9_rsv_and_wr", 2, 32'h66, 1'b1, 32'h55, 1'b1);
        @(negedge clk);
        idle();
        b0.rd_addr[2] = 5'd9;
        #3 look("r9_still_busy", 2, 32'h66, 1'b1, 32'h66, 1'b1);

        @(negedge clk);
        idle();
        b0.wr_en = 2'b01;
        b0.wr_addr[0] = 5'd0;
        b0.wr_data[0] = 32'hFFFFFFFF;
        b0.rsv_en = 1'b1;
        b0.rsv_addr = 5'd0;
        #3;
`ifdef REGFILE_R0_ZERO_EN
        look("r0_same_cycle", 0, '0, 1'b0, '0, 1'b0);
`else
        look("r0_same_cycle", 0, 32'hFFFFFFFF, 1'b0, '0, 1'b0);
`endif
        @(negedge clk);
        idle();
        #3;
`ifdef REGFILE_R0_ZERO_EN
        look("r0_next", 0, '0, 1'b0, '0, 1'b0);
`else
        look("r0_next", 0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
`endif

        @(negedge clk);
        idle();
        b0.wr_en = 2'b01;
        b0.wr_addr[0] = 5'd30;
        b0.wr_data[0] = 32'h77;
        b0.rsv_en = 1'b1;
        b0.rsv_addr = 5'd30;
        b0.rd_addr[0] = 5'd30;
        b0.rd_addr[1] = 5'd14;
        b0.rd_addr[2] = 5'd6;
        #3 for (int i = 0; i < NRD; i++) look("oob_same_cycle", i, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        idle();
        b0.rd_addr[0] = 5'd30;
        b0.rd_addr[1] = 5'd14;
        b0.rd_addr[2] = 5'd6;
        #3 for (int i = 0; i < NRD; i++) look("oob_next", i, '0, 1'b0, '0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n = 1'b1;
            b0.wr_en = NWR'($urandom_range(0, 3));
            for (int k = 0; k < NWR; k++) begin
                b0.wr_addr[k] = rnd_addr();
                b0.wr_data[k] = $urandom;
            end
            for (int i = 0; i < NRD; i++) b0.rd_addr[i] = rnd_addr();
            b0.rsv_en = ($urandom_range(0, 2) == 0);
            b0.rsv_addr = rnd_addr();
            if ($urandom_range(0, 199) == 0) #1 rst_n = 1'b0;
        end

        @(negedge clk);
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
